// File: rtl/mesh_port_arbiter.sv
// Round-robin arbiter sharing one mesh output port among N_IN input FIFOs.
// One packet is held at a time; each grant costs a one-cycle POP phase.
module mesh_port_arbiter #(
    parameter int N_IN    = 4,
    parameter int pckg_sz = 40,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_IN-1:0]           pndng_in,
    input  logic [N_IN*pckg_sz-1:0]   data_in,
    output logic [N_IN-1:0]           pop,
    input  logic [N_IN-1:0]           req_mask,
    output logic [pckg_sz-1:0]        data_out,
    output logic                      pndng,
    input  logic                      popin,
    output logic [$clog2(N_IN)-1:0]   grant_id,
    output logic [CNT_W-1:0]          fwd_cnt
);

    localparam int IDX_W = $clog2(N_IN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [IDX_W-1:0]     sel_r;
    logic [IDX_W-1:0]     sel_next_s;
    logic [IDX_W-1:0]     rr_ptr_r;
    logic [IDX_W-1:0]     rr_ptr_next_s;
    logic [N_IN-1:0]      eff_req_s;
    logic [IDX_W:0]       pick_s;
    logic                 win_found_s;
    logic [IDX_W-1:0]     win_idx_s;
    logic [N_IN-1:0]      pop_next_s;
    logic                 pndng_next_s;
    logic [pckg_sz-1:0]   data_next_s;
    logic [IDX_W-1:0]     grant_next_s;
    logic [CNT_W-1:0]     fwd_cnt_next_s;

    // Returns {found, index}: first requester after ptr, wrapping modulo N_IN.
    // The loop runs from the farthest candidate inward so the nearest one wins.
    function automatic logic [IDX_W:0] rr_pick(input logic [N_IN-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
        logic [IDX_W:0] res;
        int             idx;
        res = {(IDX_W+1){1'b0}};
        for (int k = N_IN; k >= 1; k--) begin
            idx = (int'(ptr) + k) % N_IN;
            if (req[idx]) begin
                res = {1'b1, IDX_W'(idx)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [N_IN-1:0] to_onehot(input logic [IDX_W-1:0] idx);
        return {{(N_IN-1){1'b0}}, 1'b1} << idx;
    endfunction

    assign eff_req_s   = pndng_in & ~req_mask;
    assign pick_s      = rr_pick(eff_req_s, rr_ptr_r);
    assign win_found_s = pick_s[IDX_W];
    assign win_idx_s   = pick_s[IDX_W-1:0];

    // Next-state and next-output decode; in HOLD rr_ptr_r already equals the held grant.
    always_comb begin
        state_next_s   = state_r;
        sel_next_s     = sel_r;
        rr_ptr_next_s  = rr_ptr_r;
        data_next_s    = data_out;
        grant_next_s   = grant_id;
        fwd_cnt_next_s = fwd_cnt;
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) begin
                    sel_next_s   = win_idx_s;
                    state_next_s = ST_POP;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_POP: begin
                data_next_s   = data_in[sel_r*pckg_sz +: pckg_sz];
                grant_next_s  = sel_r;
                rr_ptr_next_s = sel_r;
                state_next_s  = ST_HOLD;
            end
            ST_HOLD: begin
                if (popin) begin
                    fwd_cnt_next_s = fwd_cnt + CNT_W'(1'b1);
                    if (win_found_s) begin
                        sel_next_s   = win_idx_s;
                        state_next_s = ST_POP;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output decode of the next state so pop and pndng leave straight from flops.
    always_comb begin
        pop_next_s   = {N_IN{1'b0}};
        pndng_next_s = 1'b0;
        if (state_next_s == ST_POP) begin
            pop_next_s = to_onehot(sel_next_s);
        end else begin
            pop_next_s = {N_IN{1'b0}};
        end
        if (state_next_s == ST_HOLD) begin
            pndng_next_s = 1'b1;
        end else begin
            pndng_next_s = 1'b0;
        end
    end

    // State, pointer and registered outputs; reset also drops any held packet.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            sel_r    <= {IDX_W{1'b0}};
            rr_ptr_r <= IDX_W'(N_IN-1);
            pop      <= {N_IN{1'b0}};
            pndng    <= 1'b0;
            data_out <= {pckg_sz{1'b0}};
            grant_id <= {IDX_W{1'b0}};
            fwd_cnt  <= {CNT_W{1'b0}};
        end else begin
            state_r  <= state_next_s;
            sel_r    <= sel_next_s;
            rr_ptr_r <= rr_ptr_next_s;
            pop      <= pop_next_s;
            pndng    <= pndng_next_s;
            data_out <= data_next_s;
            grant_id <= grant_next_s;
            fwd_cnt  <= fwd_cnt_next_s;
        end
    end

endmodule
